ddr2_cmd_sequencer: RTL and testbench
=====================================

// Module: ddr2_cmd_sequencer
// PURPOSE
//  Upstream stage feeding the DDR2 DRAM model: accepts single-word host read/write requests and
//  issues closed-page ACTIVATE -> READ/WRITE -> PRECHARGE command sequences on CS#/RAS#/CAS#/WE#.
//  Drives write data and DQS strobes; flags the read-burst window for the downstream capture stage.
//  Owns CKE power-up. One transaction in flight at a time.
// PARAMETERS
//  INIT_CYCLES  16  cycles CKE held low after reset before CKE rises
//  T_RCD        3   cycles from ACTIVATE to READ/WRITE (>=1)
//  T_RP         3   cycles from PRECHARGE to next ACTIVATE (>=1)
//  T_WR         3   NOP cycles after write postamble before PRECHARGE (>=1)
//  CL           7   read CAS latency, in cycles
//  BURST_LEN    8   read burst beats (DDR, BURST_LEN/2 clock cycles)
// PORTS
//  clk        in   1   controller clock (same edge as DRAM ck)
//  reset_n    in   1   synchronous active-low reset
//  req_valid  in   1   host request valid
//  req_ready  out  1   high only in IDLE; transfer on valid&&ready
//  req_we     in   1   1=write, 0=read
//  req_addr   in   25  {bank[24:23], row[22:10], col[9:0]}
//  req_wdata  in   16  write word
//  busy       out  1   high from accept until return to IDLE
//  rd_window  out  1   high on clock cycles where DRAM drives read beats
//  cke        out  1   clock enable
//  cs_n, ras_n, cas_n, we_n  out  1 each   command pins
//  ba         out  2   bank address
//  addr       out  13  row (ACTIVATE) / column (READ/WRITE); addr[10]=0 always (no auto-precharge)
//  dq_out     out  16  write data;   dq_oe    out 1  DQ output enable
//  dqs_out    out  2   write strobe; dqs_oe   out 1  DQS/DQS# enable (DQS# = ~dqs_out at top)
// BEHAVIOUR
//  All outputs registered. Reset values: cke=0, {cs_n,ras_n,cas_n,we_n}=4'b1111 (deselect), ba=0,
//   addr=0, dq_out=0, dq_oe=0, dqs_out=2'b00, dqs_oe=0, req_ready=0, busy=0, rd_window=0.
//  Commands: ACT 4'b0011, READ 4'b0101, WRITE 4'b0100, PRE 4'b0010, NOP 4'b0111. Each command is
//   asserted exactly one cycle; NOP otherwise after INIT.
//  FSM: INIT -> IDLE -> ACT -> RCD -> {RD -> RD_WAIT | WR -> WR_PRE -> WR_DQS -> WR_POST -> WR_REC}
//   -> PRE -> RP -> IDLE.
//  INIT: count INIT_CYCLES with cke=0, deselect; then cke=1, NOP; IDLE entered one cycle later
//   (guarantees cke high on the previous and current edge for every command).
//  IDLE: req_ready=1. On accept latch we/addr/wdata; next cycle ACT with ba=bank, addr=row.
//  RCD: NOP for T_RCD-1 cycles; then READ/WRITE with ba=bank, addr={3'b0,col}.
//  Write (cycles after WRITE cmd): +1 dq_oe=dqs_oe=1, dqs=00, dq_out=wdata (preamble);
//   +2 dqs=11 (rising edge captures data); +3 dqs=00 (postamble); +4 dq_oe=dqs_oe=0;
//   then T_WR NOP cycles, then PRE.
//  Read: NOP for CL+BURST_LEN/2+1 cycles after READ; rd_window=1 on cycles CL+1..CL+BURST_LEN/2
//   after READ; then PRE. dq_oe/dqs_oe stay 0 throughout reads.
//  PRE: ba=bank, addr=0. Then T_RP NOP cycles (the T_RP-th includes IDLE entry), req_ready rises.
//  req_valid outside IDLE ignored; host holds request until ready. No back-to-back bypass:
//   min turnaround is the full sequence.
//  Reset mid-operation: next edge forces reset values (bus released, cke low), FSM to INIT; an
//   in-flight transaction is dropped, no PRE issued.
//  Counters sized $clog2(max(INIT_CYCLES, CL+BURST_LEN/2+1, T_RCD, T_RP, T_WR)+1); terminal
//   count is exact, no wrap.
// STRUCTURE
//  Package ddr2_ctrl_pkg: command localparams, state enum, req_addr struct {bank,row,col},
//   field widths. Shared with DRAM model bench and read-capture stage.
//  Sub-module ddr2_delay_timer: loadable down-counter with done flag, one instance reused per state.
//  Top: FSM + output register block.
// TESTING
//  Reset 5 cycles, release -> cke=0 for 16 cycles, then cke=1; req_ready=1 by cycle 18.
//  Write bank 1 row 0x0123 col 0x010 data 0xBEEF -> ACT(ba=1,addr=0x0123), WRITE 3 cycles
//   later (addr=0x010), dqs 00/11/00, PRE; DRAM model stores 0xBEEF.
//  Read same location -> READ, rd_window high cycles 8..11 after READ, DRAM drives 0xBEEF
//   on first beat; PRE follows on cycle 13.
//  req_valid held during busy -> no second ACT until IDLE; second request accepted after T_RP.
//  reset_n low during WR_DQS -> next cycle dq_oe=dqs_oe=0, cke=0, deselect; restart via INIT.
//  Back-to-back write then read, different banks (0 and 3) -> two full sequences; correct ba on
//   every command; no overlap.

Source files
------------

// File: rtl/ddr2_ctrl_pkg.sv
// DDR2 controller shared definitions: command pin encodings, sequencer
// states and host address layout used by the sequencer and its neighbours.
package ddr2_ctrl_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 10;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DATA_W = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } req_addr_t;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACT,
        ST_RCD,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_PRE,
        ST_WR_DQS,
        ST_WR_POST,
        ST_WR_REC,
        ST_PRE,
        ST_RP
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr2_delay_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// Counts to zero and holds there; done flags the terminal count.
module ddr2_delay_timer #(
    parameter int CW      = 5,
    parameter int RST_VAL = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          done
);

    // Reset starts the power-up interval; a load restarts a new interval.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= CW'(RST_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ddr2_cmd_sequencer.sv
// Closed-page DDR2 command sequencer: ACT -> RD/WR -> PRE per host request,
// with write DQ/DQS drive, read-window flag and CKE power-up.
module ddr2_cmd_sequencer
    import ddr2_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 16,
    parameter int T_RCD       = 3,
    parameter int T_RP        = 3,
    parameter int T_WR        = 3,
    parameter int CL          = 7,
    parameter int BURST_LEN   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [24:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        rd_window,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [1:0]  dqs_out,
    output logic        dqs_oe
);

    localparam int RD_SPAN = CL + BURST_LEN / 2 + 1;
    localparam int CNT_MAX = max2(max2(max2(INIT_CYCLES, RD_SPAN),
                                       max2(T_RCD, T_RP)), T_WR);
    localparam int CW = $clog2(CNT_MAX + 1);

    // Load values are interval length minus one (count reaches zero on
    // the last cycle of the interval).
    localparam logic [CW-1:0] LD_RCD = CW'(max2(T_RCD - 2, 0));
    localparam logic [CW-1:0] LD_RD  = CW'(RD_SPAN - 1);
    localparam logic [CW-1:0] LD_WR  = CW'(T_WR - 1);
    localparam logic [CW-1:0] LD_RP  = CW'(max2(T_RP - 2, 0));
    // Count values in RD_WAIT whose successor cycle is a read beat cycle.
    localparam logic [CW-1:0] WIN_LO = CW'(2);
    localparam logic [CW-1:0] WIN_HI = CW'(BURST_LEN / 2 + 1);

    state_t          state;
    logic [3:0]      cmd;
    logic            lat_we;
    req_addr_t       lat_addr;
    logic [15:0]     lat_wdata;
    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic [CW-1:0]   tmr_cnt;
    logic            tmr_done;
    logic [3:0]      cas_cmd;
    state_t          cas_state;
    logic [12:0]     col_addr;

    assign {cs_n, ras_n, cas_n, we_n} = cmd;
    assign cas_cmd   = lat_we ? CMD_WRITE : CMD_READ;
    assign cas_state = lat_we ? ST_WR : ST_RD;
    assign col_addr  = {3'b000, lat_addr.col};

    ddr2_delay_timer #(
        .CW      (CW),
        .RST_VAL (INIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .done     (tmr_done)
    );

    // Arm the timer from the single-cycle state preceding each wait.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (1'b1)
            (state == ST_ACT):     begin tmr_load = 1'b1; tmr_val = LD_RCD; end
            (state == ST_RD):      begin tmr_load = 1'b1; tmr_val = LD_RD;  end
            (state == ST_WR_POST): begin tmr_load = 1'b1; tmr_val = LD_WR;  end
            (state == ST_PRE):     begin tmr_load = 1'b1; tmr_val = LD_RP;  end
            default: ;
        endcase
    end

    // Sequencer FSM; every output is registered alongside the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            cmd       <= CMD_DESEL;
            cke       <= 1'b0;
            ba        <= '0;
            addr      <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            dqs_out   <= 2'b00;
            dqs_oe    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rd_window <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            cmd       <= CMD_NOP;
            rd_window <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    if (!cke) begin
                        if (tmr_done) cke <= 1'b1;
                        else          cmd <= CMD_DESEL;
                    end else begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr_t'(req_addr);
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_ACT;
                        cmd       <= CMD_ACT;
                        ba        <= req_addr[24:23];
                        addr      <= req_addr[22:10];
                    end
                end
                ST_ACT: begin
                    if (T_RCD > 1) begin
                        state <= ST_RCD;
                    end else begin
                        state <= cas_state;
                        cmd   <= cas_cmd;
                        ba    <= lat_addr.bank;
                        addr  <= col_addr;
                    end
                end
                ST_RCD: begin
                    if (tmr_done) begin
                        state <= cas_state;
                        cmd   <= cas_cmd;
                        ba    <= lat_addr.bank;
                        addr  <= col_addr;
                    end
                end
                ST_RD: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rd_window <= (tmr_cnt >= WIN_LO) && (tmr_cnt <= WIN_HI);
                    if (tmr_done) begin
                        state <= ST_PRE;
                        cmd   <= CMD_PRE;
                        ba    <= lat_addr.bank;
                        addr  <= '0;
                    end
                end
                ST_WR: begin
                    state   <= ST_WR_PRE;
                    dq_oe   <= 1'b1;
                    dqs_oe  <= 1'b1;
                    dqs_out <= 2'b00;
                    dq_out  <= lat_wdata;
                end
                ST_WR_PRE: begin
                    state   <= ST_WR_DQS;
                    dqs_out <= 2'b11;
                end
                ST_WR_DQS: begin
                    state   <= ST_WR_POST;
                    dqs_out <= 2'b00;
                end
                ST_WR_POST: begin
                    state  <= ST_WR_REC;
                    dq_oe  <= 1'b0;
                    dqs_oe <= 1'b0;
                    dq_out <= '0;
                end
                ST_WR_REC: begin
                    if (tmr_done) begin
                        state <= ST_PRE;
                        cmd   <= CMD_PRE;
                        ba    <= lat_addr.bank;
                        addr  <= '0;
                    end
                end
                ST_PRE: begin
                    if (T_RP > 1) begin
                        state <= ST_RP;
                    end else begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_RP: begin
                    if (tmr_done) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// Bench for ddr2_cmd_sequencer: per-cycle compare of all outputs against
// an event-schedule model built from each accepted request.
module tb_ddr2_cmd_sequencer;

    localparam int INIT_CYCLES = 16;
    localparam int T_RCD       = 3;
    localparam int T_RP        = 3;
    localparam int T_WR        = 3;
    localparam int CL          = 7;
    localparam int BURST_LEN   = 8;

    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_RD    = 4'b0101;
    localparam logic [3:0] C_WR    = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_DESEL = 4'b1111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [24:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        busy, rd_window, cke;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [1:0]  dqs_out;
    logic        dqs_oe;

    always #5 clk = ~clk;

    ddr2_cmd_sequencer #(
        .INIT_CYCLES (INIT_CYCLES),
        .T_RCD       (T_RCD),
        .T_RP        (T_RP),
        .T_WR        (T_WR),
        .CL          (CL),
        .BURST_LEN   (BURST_LEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .rd_window (rd_window),
        .cke       (cke),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .ba        (ba),
        .addr      (addr),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .dqs_out   (dqs_out),
        .dqs_oe    (dqs_oe)
    );

    typedef struct {
        int          a;
        bit          we;
        logic [24:0] ad;
        logic [15:0] wd;
    } txn_t;

    txn_t txq[$];
    int   cyc = 0;
    bit   rst_edge;
    int   n_vec = 0;
    int   n_err = 0;

    // Cycle index: number of edges since reset was released.
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    function automatic int act_cyc(txn_t t);
        return t.a + 1;
    endfunction

    function automatic int cas_cyc(txn_t t);
        return t.a + 1 + T_RCD;
    endfunction

    function automatic int pre_cyc(txn_t t);
        if (t.we) return cas_cyc(t) + 4 + T_WR;
        return cas_cyc(t) + CL + BURST_LEN / 2 + 2;
    endfunction

    function automatic bit model_busy(int c);
        foreach (txq[i])
            if (c >= act_cyc(txq[i]) && c < pre_cyc(txq[i]) + T_RP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_ready(int c);
        return (c >= INIT_CYCLES + 2) && !model_busy(c);
    endfunction

    function automatic logic [42:0] exp_vec(int c, bit rst);
        logic        cke_e = 1'b0;
        logic [3:0]  cmd_e = C_DESEL;
        logic [1:0]  ba_e = '0;
        logic [12:0] ad_e = '0;
        logic        oe_e = 1'b0;
        logic [1:0]  dqs_e = '0;
        logic [15:0] dq_e = '0;
        logic        rdw_e = 1'b0;
        if (rst) return {cke_e, cmd_e, 38'b0};
        cke_e = (c > INIT_CYCLES);
        cmd_e = cke_e ? C_NOP : C_DESEL;
        foreach (txq[i]) begin
            txn_t t = txq[i];
            int   k = c - cas_cyc(txq[i]);
            if (c == act_cyc(t)) begin
                cmd_e = C_ACT; ba_e = t.ad[24:23]; ad_e = t.ad[22:10];
            end
            if (k == 0) begin
                cmd_e = t.we ? C_WR : C_RD;
                ba_e  = t.ad[24:23];
                ad_e  = {3'b000, t.ad[9:0]};
            end
            if (c == pre_cyc(t)) begin
                cmd_e = C_PRE; ba_e = t.ad[24:23]; ad_e = '0;
            end
            if (t.we && k >= 1 && k <= 3) begin
                oe_e  = 1'b1;
                dqs_e = (k == 2) ? 2'b11 : 2'b00;
                dq_e  = t.wd;
            end
            if (!t.we && k > CL && k <= CL + BURST_LEN / 2) rdw_e = 1'b1;
        end
        return {cke_e, cmd_e, ba_e, ad_e, oe_e, oe_e, dqs_e, dq_e, rdw_e,
                model_ready(c), model_busy(c)};
    endfunction

    function automatic logic [42:0] obs_vec();
        logic [3:0] cm = {cs_n, ras_n, cas_n, we_n};
        bit         is_cmd = !(cm == C_NOP || cm == C_DESEL);
        return {cke, cm, is_cmd ? ba : 2'b00, is_cmd ? addr : 13'h0,
                dq_oe, dqs_oe, dqs_out, dq_oe ? dq_out : 16'h0,
                rd_window, req_ready, busy};
    endfunction

    task automatic chk(string tag, logic [42:0] got, logic [42:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        rst_edge = !reset_n;
        @(negedge clk);
        chk($sformatf("cyc%0d", cyc), obs_vec(), exp_vec(cyc, rst_edge));
    endtask

    task automatic do_req(bit we, logic [24:0] ad, logic [15:0] wd, int gap);
        txn_t t;
        bit   got = 1'b0;
        repeat (gap) step();
        req_we    = we;
        req_addr  = ad;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            if (model_ready(cyc)) begin
                t.a = cyc; t.we = we; t.ad = ad; t.wd = wd;
                txq.push_back(t);
                got = 1'b1;
            end
            step();
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 25'($urandom);
        req_wdata = 16'($urandom);
        chk("accept", 43'(got), 43'd1);
    endtask

    task automatic rand_reqs(int n);
        for (int i = 0; i < n; i++)
            do_req(1'($urandom), 25'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)));
    endtask

    initial begin
        int tgt;
        repeat (5) step();
        reset_n = 1'b1;

        do_req(1'b1, {2'd1, 13'h0123, 10'h010}, 16'hBEEF, 2);
        do_req(1'b0, {2'd1, 13'h0123, 10'h010}, 16'h0000, 1);
        do_req(1'b1, {2'd0, 13'h1A5A, 10'h3FF}, 16'h1234, 0);
        do_req(1'b0, {2'd3, 13'h1FFF, 10'h000}, 16'hFFFF, 0);
        rand_reqs(10);

        do_req(1'b1, {2'd2, 13'h0042, 10'h155}, 16'hA5C3, 1);
        tgt = cas_cyc(txq[$]) + 2;
        for (int n = 0; n < 50 && cyc < tgt; n++) step();
        reset_n = 1'b0;
        step();
        step();
        txq.delete();
        reset_n = 1'b1;

        rand_reqs(6);
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
